// File: rtl/snn_timestep_scheduler.sv
// snn_timestep_scheduler: steps the 256-neuron core through a run of timesteps.
// Define SCHED_IRQ_EN to add a sticky completion interrupt (irq_o / irq_clr_i).
module snn_timestep_scheduler #(
    parameter int NUM_AXONS   = 256,
    parameter int EVAL_CYCLES = 2,
    parameter int STEP_W      = 8,
    parameter int ADDR_W      = 11
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [STEP_W-1:0]    num_steps_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 param_in_en_o,
    output logic                 in_rd_en_o,
    output logic [ADDR_W-1:0]    in_rd_addr_o,
    input  logic [31:0]          in_rd_data_i,
    output logic [NUM_AXONS-1:0] spike_axon_o,
    input  logic [NUM_AXONS-1:0] spike_neuron_i,
    output logic                 out_wr_en_o,
    output logic [ADDR_W-1:0]    out_wr_addr_o,
    output logic [31:0]          out_wr_data_o,
`ifdef SCHED_IRQ_EN
    output logic                 irq_o,
    input  logic                 irq_clr_i,
`endif
    input  logic                 out_wr_ready_i
);

    localparam int WORDS  = NUM_AXONS / 32;
    localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int EVAL_W = $clog2(EVAL_CYCLES + 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS - 1);
    localparam logic [EVAL_W-1:0] LAST_EVAL = EVAL_W'(EVAL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        FETCH_WAIT,
        EVAL,
        CAPTURE,
        STORE,
        NEXT,
        DONE
    } state_t;

    state_t                state;
    logic [STEP_W-1:0]     step;
    logic [STEP_W-1:0]     num_steps_q;
    logic [STEP_W:0]       step_inc;
    logic [WORD_W-1:0]     word;
    logic [EVAL_W-1:0]     eval_cnt;
    logic [NUM_AXONS-1:0]  staging;
    logic [NUM_AXONS-1:0]  staged_full;
    logic [NUM_AXONS-1:0]  out_buf;
    logic                  last_step;

    // Memory layout: each step owns WORDS consecutive words; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [STEP_W-1:0] s,
        input logic [WORD_W-1:0] k
    );
        word_addr = ADDR_W'(32'(s) * WORDS + 32'(k));
    endfunction

    assign step_inc  = {1'b0, step} + 1'b1;
    assign last_step = (step_inc == {1'b0, num_steps_q});

    // The last word arrives in FETCH_WAIT; merge it so the axon vector updates in one step.
    always_comb begin
        staged_full = staging;
        staged_full[NUM_AXONS-32 +: 32] = in_rd_data_i;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state         <= IDLE;
            step          <= '0;
            num_steps_q   <= '0;
            word          <= '0;
            eval_cnt      <= '0;
            staging       <= '0;
            out_buf       <= '0;
            spike_axon_o  <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            param_in_en_o <= 1'b1;
            in_rd_en_o    <= 1'b0;
            in_rd_addr_o  <= '0;
            out_wr_en_o   <= 1'b0;
            out_wr_addr_o <= '0;
            out_wr_data_o <= '0;
        end else if (abort_i && state != IDLE) begin
            state         <= IDLE;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            param_in_en_o <= 1'b1;
            in_rd_en_o    <= 1'b0;
            out_wr_en_o   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        num_steps_q   <= num_steps_i;
                        step          <= '0;
                        word          <= '0;
                        busy_o        <= 1'b1;
                        param_in_en_o <= 1'b0;
                        if (num_steps_i == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state        <= FETCH;
                            in_rd_en_o   <= 1'b1;
                            in_rd_addr_o <= word_addr('0, '0);
                        end
                    end
                end
                FETCH: begin
                    if (word != '0)
                        staging[32*(int'(word)-1) +: 32] <= in_rd_data_i;
                    if (word == LAST_WORD) begin
                        state      <= FETCH_WAIT;
                        in_rd_en_o <= 1'b0;
                    end else begin
                        word         <= word + 1'b1;
                        in_rd_addr_o <= word_addr(step, word + 1'b1);
                    end
                end
                FETCH_WAIT: begin
                    staging      <= staged_full;
                    spike_axon_o <= staged_full;
                    eval_cnt     <= '0;
                    state        <= EVAL;
                end
                EVAL: begin
                    if (eval_cnt == LAST_EVAL)
                        state <= CAPTURE;
                    else
                        eval_cnt <= eval_cnt + 1'b1;
                end
                CAPTURE: begin
                    out_buf       <= spike_neuron_i;
                    word          <= '0;
                    state         <= STORE;
                    out_wr_en_o   <= 1'b1;
                    out_wr_addr_o <= word_addr(step, '0);
                    out_wr_data_o <= spike_neuron_i[31:0];
                end
                STORE: begin
                    if (out_wr_ready_i) begin
                        if (word == LAST_WORD) begin
                            out_wr_en_o <= 1'b0;
                            state       <= NEXT;
                        end else begin
                            word          <= word + 1'b1;
                            out_wr_addr_o <= word_addr(step, word + 1'b1);
                            out_wr_data_o <= out_buf[32*(int'(word)+1) +: 32];
                        end
                    end
                end
                NEXT: begin
                    step <= step + 1'b1;
                    word <= '0;
                    if (last_step) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end else begin
                        state        <= FETCH;
                        in_rd_en_o   <= 1'b1;
                        in_rd_addr_o <= word_addr(step + 1'b1, '0);
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    done_o        <= 1'b0;
                    busy_o        <= 1'b0;
                    param_in_en_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCHED_IRQ_EN
    logic to_done;

    // Rises together with done_o; an abort never reaches DONE so never sets it.
    assign to_done = (state == IDLE && start_i && num_steps_i == '0)
                   || (state == NEXT && !abort_i && last_step);

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i)
            irq_o <= 1'b0;
        else if (irq_clr_i)
            irq_o <= 1'b0;
        else if (to_done)
            irq_o <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// tb_snn_timestep_scheduler: directed runs with random memory and core masks
// against a step/word reference model of the scheduler's memory traffic.
module tb_snn_timestep_scheduler;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [7:0]   num_steps = '0;
    logic         busy, done, param_en, rd_en, wr_en;
    logic [10:0]  rd_addr, wr_addr;
    logic [31:0]  rd_data = '0;
    logic [31:0]  wr_data;
    logic [255:0] axon, neuron;
    logic         ready = 1'b1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0]  mem [2048];
    logic [255:0] mask = '0;

    int           wr_q_addr [$];
    logic [31:0]  wr_q_data [$];
    int           rd_q [$];
    int           done_cnt = 0;
    int           done_cyc = 0;
    int           wcnt = 0;
    int           run_w = -1;
    int           run_len = 0;
    int           stall_idx = -1;
    int           stall_len = 0;
    int           abort_word = -1;
    logic         held_valid = 1'b0;
    logic [10:0]  held_addr = '0;
    logic [31:0]  held_data = '0;

    assign neuron = axon ^ mask;

    snn_timestep_scheduler dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst_n),
        .start_i        (start),
        .abort_i        (abort),
        .num_steps_i    (num_steps),
        .busy_o         (busy),
        .done_o         (done),
        .param_in_en_o  (param_en),
        .in_rd_en_o     (rd_en),
        .in_rd_addr_o   (rd_addr),
        .in_rd_data_i   (rd_data),
        .spike_axon_o   (axon),
        .spike_neuron_i (neuron),
        .out_wr_en_o    (wr_en),
        .out_wr_addr_o  (wr_addr),
        .out_wr_data_o  (wr_data),
        .out_wr_ready_i (ready)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Synchronous read memory: data for an address strobed in one cycle is valid the next.
    initial forever begin
        @(posedge clk);
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output-memory side: drives ready/abort, logs traffic, checks held writes.
    initial forever begin
        @(negedge clk);
        if (abort) abort = 1'b0;
        if (rst_n) begin
            if (wcnt != run_w) begin
                run_w = wcnt;
                run_len = 0;
            end
            if (wr_en && wcnt == stall_idx && run_len < stall_len) begin
                ready = 1'b0;
                run_len++;
            end else begin
                ready = 1'b1;
            end
            if (wr_en && held_valid) begin
                chk("hold_addr", 256'(wr_addr), 256'(held_addr));
                chk("hold_data", 256'(wr_data), 256'(held_data));
            end
            if (wr_en && !ready) begin
                held_valid = 1'b1;
                held_addr = wr_addr;
                held_data = wr_data;
            end else begin
                held_valid = 1'b0;
            end
            if (wr_en && wcnt == abort_word) begin
                abort = 1'b1;
            end else if (wr_en && ready) begin
                wr_q_addr.push_back(int'(wr_addr));
                wr_q_data.push_back(wr_data);
                wcnt++;
            end
            if (rd_en) rd_q.push_back(int'(rd_addr));
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input int i);
        exp_word = mem[i % 2048] ^ mask[32*(i%8) +: 32];
    endfunction

    function automatic logic [255:0] step_vec(input int s);
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = mem[(s*8 + k) % 2048];
        step_vec = v;
    endfunction

    task automatic run(input int n, input int extra, input logic [7:0] mid);
        int p0, bw, br, bd, t;
        bw = wr_q_addr.size();
        br = rd_q.size();
        bd = done_cnt;
        num_steps = n[7:0];
        start = 1'b1;
        p0 = cyc;
        tick();
        start = 1'b0;
        chk("busy_run", 256'(busy), 256'(1));
        chk("param_run", 256'(param_en), 256'(0));
        num_steps = mid;
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 0;
        while (done_cnt == bd && t < 2000) begin
            tick();
            t++;
        end
        chk("done_seen", 256'(done_cnt != bd), 256'(1));
        chk("done_cycle", 256'(done_cyc - p0), 256'(21*n + 1 + extra));
        tick();
        tick();
        chk("done_pulses", 256'(done_cnt - bd), 256'(1));
        chk("busy_idle", 256'(busy), 256'(0));
        chk("param_idle", 256'(param_en), 256'(1));
        chk("wr_count", 256'(wr_q_addr.size() - bw), 256'(8*n));
        chk("rd_count", 256'(rd_q.size() - br), 256'(8*n));
        for (int i = 0; i < 8*n && bw + i < wr_q_addr.size(); i++) begin
            chk("wr_addr", 256'(wr_q_addr[bw+i]), 256'(i % 2048));
            chk("wr_data", 256'(wr_q_data[bw+i]), 256'(exp_word(i)));
        end
        for (int i = 0; i < 8*n && br + i < rd_q.size(); i++)
            chk("rd_addr", 256'(rd_q[br+i]), 256'(i % 2048));
        if (n > 0) chk("axon_last", axon, step_vec(n - 1));
    endtask

    initial begin
        int n, bw, br, bd, t;
        for (int i = 0; i < 2048; i++) mem[i] = $urandom;
        for (int k = 0; k < 8; k++) mem[k] = 32'h1 << k;
        repeat (3) tick();
        chk("rst_param", 256'(param_en), 256'(1));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_axon", axon, 256'(0));
        chk("rst_strobes", 256'({rd_en, wr_en}), 256'(0));
        rst_n = 1'b1;
        tick();

        mask = '0;
        run(2, 0, 8'd9);

        mask = {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
        n = int'($urandom_range(1, 3));
        run(n, 0, 8'd0);

        n = int'($urandom_range(1, 3));
        stall_len = 3;
        stall_idx = wr_q_addr.size() + 2;
        run(n, 3, 8'd1);
        stall_idx = -1;

        run(0, 0, 8'd5);

        bw = wr_q_addr.size();
        br = rd_q.size();
        bd = done_cnt;
        abort_word = bw + 4;
        num_steps = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 0;
        while (!abort && t < 500) begin
            tick();
            t++;
        end
        chk("abort_seen", 256'(abort), 256'(1));
        tick();
        chk("abort_busy", 256'(busy), 256'(0));
        chk("abort_param", 256'(param_en), 256'(1));
        chk("abort_strobes", 256'({rd_en, wr_en, done}), 256'(0));
        repeat (40) tick();
        abort_word = -1;
        chk("abort_no_done", 256'(done_cnt - bd), 256'(0));
        chk("abort_wr_count", 256'(wr_q_addr.size() - bw), 256'(4));
        chk("abort_rd_count", 256'(rd_q.size() - br), 256'(8));
        chk("abort_axon", axon, step_vec(0));
        for (int i = 0; i < 4 && bw + i < wr_q_addr.size(); i++)
            chk("abort_wr_data", 256'(wr_q_data[bw+i]), 256'(exp_word(i)));

        num_steps = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 256'(busy), 256'(0));
        chk("midrst_param", 256'(param_en), 256'(1));
        chk("midrst_axon", axon, 256'(0));
        chk("midrst_strobes", 256'({rd_en, wr_en, done}), 256'(0));
        tick();
        rst_n = 1'b1;
        tick();

        n = int'($urandom_range(1, 2));
        run(n, 0, 8'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
